lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit between the core's MEM stage and the unified memory's DMEM slave port.
- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the DMEM read/write/strobe signals; the memory has a 1-cycle synchronous read.
- Aligns and sign/zero-extends load data, replicates store data onto byte lanes, and flags misaligned or illegal accesses without touching memory.

Parameters:
- XLEN, 32, data/address width (from CPU_profile; not overridden per instance).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  MEM stage presents a request.
- req_ready  output  1  LSU can accept a request this cycle.
- req_wen  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data, low bits significant.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  XLEN  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal funct3.
- dmem_addr  output  XLEN  to memory; word-aligned (addr[1:0] forced 0).
- dmem_ren  output  1  memory read enable.
- dmem_rdata  input  XLEN  memory read word, valid the cycle after ren.
- dmem_wen  output  1  memory write enable.
- dmem_wstrb  output  4  byte strobes.
- dmem_wdata  output  XLEN  lane-replicated store data.

Behaviour:
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0.
  - dmem_ren/dmem_wen are 0 while rst=1, including combinationally in the reset cycle.
- FSM states: IDLE, LOAD_WAIT, RESP.
- req_ready = (state==IDLE). Accept = req_valid & req_ready.
- Error check, evaluated in the accept cycle:
  - Load funct3 ∈ {3,6,7} or store funct3 ≥ 3 → illegal.
  - Half access with addr[0]=1 → misaligned.
  - Word access with addr[1:0]≠0 → misaligned.
- Error accept: no ren/wen. Next state RESP with resp_err=1, resp_rdata=0.
- Aligned store accept (cycle N):
  - dmem_wen=1 combinationally in cycle N.
  - Strobes: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111.
  - dmem_wdata: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
  - Next state RESP, resp_err=0, resp_rdata=0. Response visible at N+1.
- Aligned load accept (cycle N):
  - dmem_ren=1 combinationally in cycle N.
  - Register funct3 and addr[1:0]; next state LOAD_WAIT.
- LOAD_WAIT (N+1):
  - Extract from dmem_rdata:
    - Byte = lane addr[1:0]; LB sign-extends, LBU zero-extends.
    - Half = addr[1] ? [31:16] : [15:0]; LH sign-extends, LHU zero-extends.
    - LW = full word.
  - Register the result into resp_rdata; next state RESP. Response visible at N+2.
- RESP: resp_valid=1; hold resp_rdata and resp_err stable until resp_ready=1, then IDLE.
  - A new request is accepted no earlier than the cycle after the handshake.
- Throughput: stores and errors take 2 cycles per op; loads take 3 cycles per op with resp_ready held high.
- dmem_addr = {req_addr[XLEN-1:2],2'b00} whenever state==IDLE; value is don't-care otherwise but must not change while ren/wen is 0.
- Reset mid-operation: rst in any state returns to IDLE next edge; any pending response is dropped (resp_valid=0); no write is issued in the reset cycle.
- req_* inputs are sampled only on accept; their changes outside accept are ignored.

Decomposition:
- Add to CPU_profile:
  - lsu_funct3_e (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
  - lsu_state_e {IDLE, LOAD_WAIT, RESP}.
- One combinational sub-module lsu_load_align(funct3, byte_off, word → extended data), reused later by the verification model.

Test Plan:
- Preload word 0x100 = 0x804020F0. LB 0x100 → resp_rdata 0xFFFFFFF0 at N+2, err 0; LBU 0x103 → 0x00000080; LH 0x102 → 0xFFFF8040; LHU 0x102 → 0x00008040.
- SB 0x101, wdata 0x123456AB → cycle N: wen=1, wstrb=0010, wdata 0xABABABAB; then LW 0x100 → 0x8040ABF0.
- SH 0x103 → no wen/ren; resp_err=1, rdata 0 at N+1. LW 0x102 → err. Load funct3=3 → err.
- LW 0x100 with resp_ready=0 for 5 cycles → resp_valid and data held stable, req_ready=0 throughout; completes on ready=1, accepts the next request one cycle later.
- Back-to-back SW 0x104 = 0xDEADBEEF then LW 0x104, resp_ready=1 → writes land; load returns 0xDEADBEEF; accept cycles spaced by 2.
- Assert rst during LOAD_WAIT → next cycle IDLE, resp_valid=0, req_ready=1; rst asserted in a store-accept cycle → dmem_wen=0 and memory unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   CPU_XLEN       : data/address width of the core
//   lsu_funct3_e   : RV32I load funct3 encodings
//   SB/SH/SW       : RV32I store funct3 encodings (they reuse the load values 0..2)
//   lsu_state_e    : LSU control states
//   lsu_access_err : illegal-funct3 / misalignment check for one request
package lsu_pkg;

  localparam int CPU_XLEN = 32;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } lsu_funct3_e;

  // Store encodings alias the low load encodings, so they cannot live in the same enum.
  localparam logic [2:0] SB = 3'd0;
  localparam logic [2:0] SH = 3'd1;
  localparam logic [2:0] SW = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    RESP
  } lsu_state_e;

  // funct3[1:0] gives the access size for every legal encoding (0=byte, 1=half, 2=word).
  function automatic logic lsu_access_err(input logic       wen,
                                          input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic illegal;
    logic misaligned;
    if (wen) illegal = (funct3 >= 3'd3);
    else     illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    misaligned = ((funct3[1:0] == 2'd1) && off[0]) ||
                 ((funct3[1:0] == 2'd2) && (off != 2'd0));
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load data extraction.
//   funct3   : load funct3 (LB/LH/LW/LBU/LHU)
//   byte_off : low two bits of the original byte address
//   word     : aligned 32-bit memory word
//   data     : selected byte/half/word, sign- or zero-extended to XLEN
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic        [7:0]      byte_u;
  logic        [15:0]     half_u;
  logic signed [7:0]      byte_s;
  logic signed [15:0]     half_s;
  logic signed [XLEN-1:0] byte_sx;
  logic signed [XLEN-1:0] half_sx;

  assign byte_u  = word[{byte_off, 3'b000} +: 8];
  assign half_u  = byte_off[1] ? word[31:16] : word[15:0];
  assign byte_s  = $signed(byte_u);
  assign half_s  = $signed(half_u);
  assign byte_sx = XLEN'(byte_s);
  assign half_sx = XLEN'(half_s);

  always_comb begin
    data = word;
    case (funct3)
      LB:      data = byte_sx;
      LBU:     data = XLEN'(byte_u);
      LH:      data = half_sx;
      LHU:     data = XLEN'(half_u);
      default: data = word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the MEM stage and the DMEM slave port.
//   req_*   : one load/store request, valid/ready handshake (req_ready = idle)
//   resp_*  : response with extended load data and an error flag, valid/ready
//   dmem_*  : word-aligned memory port, 1-cycle synchronous read, byte strobes
// Misaligned or illegal requests never reach memory; they respond with err=1.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = CPU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_ren,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_wen,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata
);

  lsu_state_e      state;
  logic [2:0]      funct3_p0;
  logic [1:0]      off_p0;
  logic [XLEN-1:0] addr_p0;
  logic            accept;
  logic            acc_err;
  logic [XLEN-1:0] aligned_addr;
  logic [XLEN-1:0] load_data;

  assign req_ready    = (state == IDLE);
  // Gating with rst keeps memory untouched in a reset cycle even if state is IDLE.
  assign accept       = req_valid & req_ready & ~rst;
  assign acc_err      = lsu_access_err(req_wen, req_funct3, req_addr[1:0]);
  assign aligned_addr = {req_addr[XLEN-1:2], 2'b00};

  // Stage: accept cycle, memory command driven combinationally.
  assign dmem_ren  = accept & ~req_wen & ~acc_err;
  assign dmem_wen  = accept &  req_wen & ~acc_err;
  // Hold the accepted address afterwards so the port is quiet while busy.
  assign dmem_addr = (state == IDLE) ? aligned_addr : addr_p0;

  always_comb begin
    dmem_wstrb = 4'b1111;
    dmem_wdata = req_wdata;
    case (req_funct3)
      SB: begin
        dmem_wstrb = 4'b0001 << req_addr[1:0];
        dmem_wdata = {4{req_wdata[7:0]}};
      end
      SH: begin
        dmem_wstrb = 4'b0011 << req_addr[1:0];
        dmem_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        dmem_wstrb = 4'b1111;
        dmem_wdata = req_wdata;
      end
    endcase
  end

  // Stage: read data returns one cycle after ren, aligned from the latched offset.
  lsu_load_align #(.XLEN(XLEN)) u_align (
    .funct3   (funct3_p0),
    .byte_off (off_p0),
    .word     (dmem_rdata),
    .data     (load_data)
  );

  // Stage: control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_p0   <= aligned_addr;
            funct3_p0 <= req_funct3;
            off_p0    <= req_addr[1:0];
            if (acc_err || req_wen) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= acc_err;
              resp_rdata <= '0;
            end else begin
              state <= LOAD_WAIT;
            end
          end
        end
        LOAD_WAIT: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_data;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dmem_addr;
  logic        dmem_ren;
  logic [31:0] dmem_rdata;
  logic        dmem_wen;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dmem_addr  (dmem_addr),
    .dmem_ren   (dmem_ren),
    .dmem_rdata (dmem_rdata),
    .dmem_wen   (dmem_wen),
    .dmem_wstrb (dmem_wstrb),
    .dmem_wdata (dmem_wdata)
  );

  always #5 clk = ~clk;

  // Behavioural DMEM: 1-cycle synchronous read, byte-strobed write.
  logic [31:0] mem [0:255];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      mem[64] <= 32'h804020F0;
      loaded  <= 1'b1;
    end
    if (dmem_ren) dmem_rdata <= mem[dmem_addr[9:2]];
    if (dmem_wen)
      for (int i = 0; i < 4; i++)
        if (dmem_wstrb[i]) mem[dmem_addr[9:2]][8*i +: 8] <= dmem_wdata[8*i +: 8];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          acc;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  // Monitor: pops an expectation on every response handshake.
  int first_cyc = 0;
  int last_hs   = 0;
  logic prev_v  = 1'b0;
  always @(negedge clk) begin
    exp_t it;
    if (!rst) begin
      if (resp_valid && !prev_v) first_cyc = cyc;
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          it = sb_q.pop_front();
          chk({it.name, "_rdata"}, resp_rdata, it.d);
          chk({it.name, "_err"}, 32'(resp_err), 32'(it.e));
          chk({it.name, "_latency"}, 32'(first_cyc - it.acc), 32'(it.lat));
        end
        last_hs = cyc;
      end
    end
    prev_v = resp_valid;
  end

  task automatic do_req(input string name, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                        input logic push, output int acc);
    int t;
    exp_t it;
    @(negedge clk);
    req_valid = 1'b1; req_wen = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
    #1;
    acc = cyc;
    chk({name, "_ren"}, 32'(dmem_ren), 32'(!w && !exp_e));
    chk({name, "_wen"}, 32'(dmem_wen), 32'(w && !exp_e));
    if (!exp_e) chk({name, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    if (w && !exp_e) begin
      chk({name, "_wstrb"}, 32'(dmem_wstrb), 32'(exp_strb));
      chk({name, "_wdata"}, dmem_wdata, exp_wd);
    end
    if (push) begin
      it.d = exp_d; it.e = exp_e; it.acc = acc; it.lat = (w || exp_e) ? 1 : 2; it.name = name;
      sb_q.push_back(it);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, t;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state, with a load presented during reset.
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'd2; req_addr = 32'h100;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_ren", 32'(dmem_ren), 32'd0);
    chk("rst_wen", 32'(dmem_wen), 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Loads with extension.
    do_req("lb_100",  1'b0, 3'd0, 32'h100, 0, 32'hFFFFFFF0, 1'b0, 0, 0, 1'b1, a0);
    do_req("lbu_103", 1'b0, 3'd4, 32'h103, 0, 32'h00000080, 1'b0, 0, 0, 1'b1, a0);
    do_req("lh_102",  1'b0, 3'd1, 32'h102, 0, 32'hFFFF8040, 1'b0, 0, 0, 1'b1, a0);
    do_req("lhu_102", 1'b0, 3'd5, 32'h102, 0, 32'h00008040, 1'b0, 0, 0, 1'b1, a0);

    // Byte store then word readback.
    do_req("sb_101", 1'b1, 3'd0, 32'h101, 32'h123456AB, 32'h0, 1'b0,
           4'b0010, 32'hABABABAB, 1'b1, a0);
    do_req("lw_100", 1'b0, 3'd2, 32'h100, 0, 32'h8040ABF0, 1'b0, 0, 0, 1'b1, a0);

    // Errors.
    do_req("sh_103_mis", 1'b1, 3'd1, 32'h103, 32'h5555, 32'h0, 1'b1, 0, 0, 1'b1, a0);
    do_req("lw_102_mis", 1'b0, 3'd2, 32'h102, 0, 32'h0, 1'b1, 0, 0, 1'b1, a0);
    do_req("ld_f3_3",    1'b0, 3'd3, 32'h100, 0, 32'h0, 1'b1, 0, 0, 1'b1, a0);
    do_req("st_f3_4",    1'b1, 3'd4, 32'h100, 0, 32'h0, 1'b1, 0, 0, 1'b1, a0);

    // Backpressure: response held for 5 cycles.
    @(posedge clk); #1 resp_ready = 1'b0;
    do_req("lw_stall", 1'b0, 3'd2, 32'h100, 0, 32'h8040ABF0, 1'b0, 0, 0, 1'b1, a0);
    t = 0;
    while (!resp_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, 32'h8040ABF0);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    do_req("sh_106", 1'b1, 3'd1, 32'h106, 32'h0000BEEF, 32'h0, 1'b0,
           4'b1100, 32'hBEEFBEEF, 1'b1, a1);
    chk("accept_after_hs", 32'(a1 - last_hs), 32'd1);

    // Back-to-back store then load.
    do_req("sw_104", 1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0, 1'b0,
           4'b1111, 32'hDEADBEEF, 1'b1, a0);
    do_req("lw_104", 1'b0, 3'd2, 32'h104, 0, 32'hDEADBEEF, 1'b0, 0, 0, 1'b1, a1);
    chk("b2b_spacing", 32'(a1 - a0), 32'd2);

    // Reset during LOAD_WAIT: response dropped.
    do_req("lw_rst", 1'b0, 3'd2, 32'h104, 0, 32'h0, 1'b0, 0, 0, 1'b0, a0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_lw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_lw_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Reset in a store-accept cycle: no write issued.
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h100; req_wdata = 32'h0;
    #1;
    chk("rst_st_wen", 32'(dmem_wen), 32'd0);
    @(posedge clk); #1 begin rst = 1'b0; req_valid = 1'b0; end
    do_req("lw_unchanged", 1'b0, 3'd2, 32'h100, 0, 32'h8040ABF0, 1'b0, 0, 0, 1'b1, a0);

    t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
